bcd_tick_counter: RTL and testbench
===================================

// Module: bcd_tick_counter
// PURPOSE
//  Multi-digit BCD counter on a prescaled time base, with per-digit active-low 7-segment outputs.
//  Supports up/down counting, pause, parallel load and leading-zero blanking.
//  Sits between board clock/switches and the HEX displays; the generalised stopwatch/counter block.
// PARAMETERS
//  CLK_HZ    50_000_000  input clock frequency
//  TICK_HZ   1           count rate; DIV = CLK_HZ/TICK_HZ (must divide exactly, DIV >= 2)
//  N_DIGITS  4           number of BCD digits (1..8); digit 0 = least significant
// PORTS
//  G_CLOCK_50  in   1           single clock, all logic rising-edge
//  G_RESET     in   1           synchronous, active-high reset
//  I_EN        in   1           1 = run; 0 = freeze prescaler and digits
//  I_UP        in   1           1 = count up, 0 = count down
//  I_LOAD      in   1           synchronous load strobe
//  I_LOAD_BCD  in   4*N_DIGITS  load value; digit i = [4i+3:4i]
//  I_BLANK_LZ  in   1           1 = blank leading zeros
//  O_BCD       out  4*N_DIGITS  current count, registered
//  O_HEX       out  7*N_DIGITS  digit i = [7i+6:7i], order {a,b,c,d,e,f,g} MSB..LSB, active-low
//  O_TICK      out  1           one-cycle pulse, registered, in the cycle a tick step becomes visible
//  O_WRAP      out  1           one-cycle pulse, registered, with O_TICK when the count wrapped
// BEHAVIOUR
//  Priority per edge: G_RESET > I_LOAD > tick step. Reset/load never delayed.
//  Reset: prescaler=0, all digits=0, O_TICK=0, O_WRAP=0; O_HEX shows "0" on every digit
//   (7'b0000001), or only on digit 0 with all others 7'h7F when I_BLANK_LZ=1.
//  Prescaler: counts 0..DIV-1 while I_EN=1; holds while I_EN=0. Step = (pre==DIV-1 && I_EN);
//   on a step, pre->0. First step after reset release: new value visible DIV cycles later.
//   Exactly one step per DIV enabled cycles, no extra cycle of period.
//  Up step: digit 0 +1; a digit at 9 goes to 0 and carries; all-9s -> all-0s, O_WRAP=1.
//  Down step: digit 0 -1; a digit at 0 goes to 9 and borrows; all-0s -> all-9s, O_WRAP=1.
//  I_UP is sampled only on step edges; changing it between steps has no other effect.
//  Load: digits <= I_LOAD_BCD with any nibble >9 clamped to 9; prescaler <= 0;
//   O_TICK=0 and O_WRAP=0 next cycle. Load wins over a simultaneous step, and the step is lost.
//   Load works with I_EN=0.
//  O_TICK/O_WRAP are 1 only in the cycle after a step edge, otherwise 0.
//  O_HEX: combinational decode of the digit registers. 0..9 use the standard patterns:
//   0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//   5=0100100 6=0100000 7=0001111 8=0000000 9=0000100
//   Any other code -> 7'h7F (not reachable).
//  Blanking: with I_BLANK_LZ=1, digit i>0 is 7'h7F if it and all higher digits are 0.
//   Digit 0 is never blanked. The mode takes effect combinationally.
//  Reset mid-count (any prescaler value) restarts the full DIV period from 0.
// STRUCTURE
//  Package bcd_disp_pkg: SEG_BLANK, the 10-entry segment constant table, BCD_W=4, SEG_W=7,
//   and function bcd_to_seg. Shared with the other display blocks.
//  Sub-module bcd_seg7_decoder (4-bit in, 7-bit out, active-low), instantiated N_DIGITS times
//   via generate. The prescaler and digit chain live in this module.
//  Elaboration check: CLK_HZ % TICK_HZ == 0 and DIV >= 2, else $error.
// TESTING (CLK_HZ=10, TICK_HZ=1 -> DIV=10, N_DIGITS=4 unless stated)
//  1 Reset, EN=1, UP=1: O_BCD=0000 for 9 cycles, 0001 on cycle 10 with O_TICK=1 for 1 cycle;
//    O_HEX digit0=1001111.
//  2 Load 0x9998, UP=1: next steps 9999, then 0000 with O_WRAP=1 and O_TICK=1 in the same cycle.
//  3 Load 0x0001, UP=0: steps 0000, then 9999 with O_WRAP=1; 0x0100 steps to 0099 (borrow chain).
//  4 EN=0 for 25 cycles mid-period (pre=4): no step; step occurs 6 enabled cycles after EN returns.
//  5 Load 0xFA37 -> O_BCD=0x9937. Load on the step edge -> loaded value held; next step DIV later.
//  6 BLANK_LZ=1, count 0x0070: digits 3,2=7F, 1=0001111, 0=0000001; count 0 shows only digit0 "0";
//    G_RESET at pre=7 -> 0000, next step 10 cycles later.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared 7-segment display definitions: widths, active-low segment table and BCD decode.
package bcd_disp_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  // Segment order {a,b,c,d,e,f,g}, MSB..LSB, active-low
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

  // Non-decimal codes show nothing rather than a misleading glyph
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
    logic [SEG_W-1:0] seg;
    case (bcd)
      4'd0:    seg = SEG_TABLE[0];
      4'd1:    seg = SEG_TABLE[1];
      4'd2:    seg = SEG_TABLE[2];
      4'd3:    seg = SEG_TABLE[3];
      4'd4:    seg = SEG_TABLE[4];
      4'd5:    seg = SEG_TABLE[5];
      4'd6:    seg = SEG_TABLE[6];
      4'd7:    seg = SEG_TABLE[7];
      4'd8:    seg = SEG_TABLE[8];
      4'd9:    seg = SEG_TABLE[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Single-digit BCD to active-low 7-segment decoder.
module bcd_seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter stepped by a prescaled tick, with load,
// pause and leading-zero blanking on active-low 7-segment outputs.
module bcd_tick_counter
  import bcd_disp_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int N_DIGITS = 4
) (
  input  logic                      G_CLOCK_50,
  input  logic                      G_RESET,
  input  logic                      I_EN,
  input  logic                      I_UP,
  input  logic                      I_LOAD,
  input  logic [BCD_W*N_DIGITS-1:0] I_LOAD_BCD,
  input  logic                      I_BLANK_LZ,
  output logic [BCD_W*N_DIGITS-1:0] O_BCD,
  output logic [SEG_W*N_DIGITS-1:0] O_HEX,
  output logic                      O_TICK,
  output logic                      O_WRAP
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW    = BCD_W * N_DIGITS;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  if (((CLK_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_div
    $error("bcd_tick_counter: CLK_HZ must be an exact multiple of TICK_HZ with DIV >= 2");
  end
  if ((N_DIGITS < 1) || (N_DIGITS > 8)) begin : g_bad_digits
    $error("bcd_tick_counter: N_DIGITS must be in 1..8");
  end

  // Load values above 9 saturate to 9 so the digit chain never holds a non-decimal code
  function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [PRE_W-1:0] pre_p0;
  logic             step_p0;
  logic [BW-1:0]    bcd_p1;
  logic             tick_p1;
  logic             wrap_p1;

  logic [BW-1:0]       bcd_nxt;
  logic                carry_out;
  logic [BW-1:0]       load_sat;
  logic [N_DIGITS-1:0] blank;
  logic [SEG_W*N_DIGITS-1:0] seg_raw;

  // ---- Stage p0: prescaler and step decision ----
  assign step_p0 = I_EN && (pre_p0 == PRE_LAST);

  // Ripple the +1 / -1 through the digits; carry_out set means every digit rolled over
  always_comb begin
    bcd_nxt   = bcd_p1;
    carry_out = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry_out) begin
        if (I_UP) begin
          if (bcd_p1[i*BCD_W +: BCD_W] == 4'd9) begin
            bcd_nxt[i*BCD_W +: BCD_W] = 4'd0;
          end else begin
            bcd_nxt[i*BCD_W +: BCD_W] = bcd_p1[i*BCD_W +: BCD_W] + 4'd1;
            carry_out = 1'b0;
          end
        end else begin
          if (bcd_p1[i*BCD_W +: BCD_W] == 4'd0) begin
            bcd_nxt[i*BCD_W +: BCD_W] = 4'd9;
          end else begin
            bcd_nxt[i*BCD_W +: BCD_W] = bcd_p1[i*BCD_W +: BCD_W] - 4'd1;
            carry_out = 1'b0;
          end
        end
      end
    end
  end

  // Per-digit saturation of the parallel load value
  always_comb begin
    load_sat = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      load_sat[i*BCD_W +: BCD_W] = sat_bcd(I_LOAD_BCD[i*BCD_W +: BCD_W]);
    end
  end

  // ---- Stage p1: registered count and tick/wrap pulses ----
  // Reset beats load beats step; a step coinciding with a load is dropped
  always_ff @(posedge G_CLOCK_50) begin
    if (G_RESET) begin
      pre_p0  <= '0;
      bcd_p1  <= '0;
      tick_p1 <= 1'b0;
      wrap_p1 <= 1'b0;
    end else if (I_LOAD) begin
      pre_p0  <= '0;
      bcd_p1  <= load_sat;
      tick_p1 <= 1'b0;
      wrap_p1 <= 1'b0;
    end else begin
      tick_p1 <= step_p0;
      wrap_p1 <= step_p0 && carry_out;
      if (step_p0) begin
        pre_p0 <= '0;
        bcd_p1 <= bcd_nxt;
      end else if (I_EN) begin
        pre_p0 <= pre_p0 + PRE_W'(1);
      end
    end
  end

  assign O_BCD  = bcd_p1;
  assign O_TICK = tick_p1;
  assign O_WRAP = wrap_p1;

  // A digit above 0 blanks only while it and everything above it are zero
  always_comb begin
    logic lz;
    blank = '0;
    lz    = I_BLANK_LZ;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz       = lz && (bcd_p1[i*BCD_W +: BCD_W] == 4'd0);
      blank[i] = lz;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_seg7_decoder u_dec (
      .bcd (bcd_p1[g*BCD_W +: BCD_W]),
      .seg (seg_raw[g*SEG_W +: SEG_W])
    );
    assign O_HEX[g*SEG_W +: SEG_W] = blank[g] ? SEG_BLANK : seg_raw[g*SEG_W +: SEG_W];
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with CLK_HZ=10, TICK_HZ=1 (DIV=10), 4 digits.
module tb_bcd_tick_counter;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] SB = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_bcd;
  logic        blank_lz;
  logic [15:0] bcd;
  logic [27:0] hex;
  logic        tick;
  logic        wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_tick_counter #(
    .CLK_HZ   (10),
    .TICK_HZ  (1),
    .N_DIGITS (4)
  ) dut (
    .G_CLOCK_50 (clk),
    .G_RESET    (rst),
    .I_EN       (en),
    .I_UP       (up),
    .I_LOAD     (load),
    .I_LOAD_BCD (load_bcd),
    .I_BLANK_LZ (blank_lz),
    .O_BCD      (bcd),
    .O_HEX      (hex),
    .O_TICK     (tick),
    .O_WRAP     (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_bcd = v;
    load     = 1'b1;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bcd = '0; blank_lz = 1'b0;
    cyc(2);

    // Reset state
    chk("rst_bcd",  32'(bcd),  32'h0000);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_hex",  32'(hex),  32'({S0, S0, S0, S0}));
    blank_lz = 1'b1;
    #1;
    chk("rst_hex_blank", 32'(hex), 32'({SB, SB, SB, S0}));
    blank_lz = 1'b0;

    // 1: first step lands on the 10th edge after release
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      chk("t1_hold", 32'(bcd), 32'h0000);
    end
    cyc(1);
    chk("t1_step", 32'(bcd),       32'h0001);
    chk("t1_tick", 32'(tick),      32'h1);
    chk("t1_wrap", 32'(wrap),      32'h0);
    chk("t1_hex0", 32'(hex[6:0]),  32'(S1));
    cyc(1);
    chk("t1_tick_off", 32'(tick), 32'h0);

    // 2: up wrap
    do_load(16'h9998);
    chk("t2_load", 32'(bcd),  32'h9998);
    chk("t2_ltick", 32'(tick), 32'h0);
    cyc(10);
    chk("t2_9999", 32'(bcd),  32'h9999);
    chk("t2_nowrap", 32'(wrap), 32'h0);
    cyc(10);
    chk("t2_0000", 32'(bcd),  32'h0000);
    chk("t2_tick", 32'(tick), 32'h1);
    chk("t2_wrap", 32'(wrap), 32'h1);
    cyc(1);
    chk("t2_wrap_off", 32'(wrap), 32'h0);

    // 3: down wrap and borrow chain
    up = 1'b0;
    do_load(16'h0001);
    cyc(10);
    chk("t3_0000", 32'(bcd),  32'h0000);
    chk("t3_nowrap", 32'(wrap), 32'h0);
    cyc(10);
    chk("t3_9999", 32'(bcd),  32'h9999);
    chk("t3_wrap", 32'(wrap), 32'h1);
    do_load(16'h0100);
    cyc(10);
    chk("t3_borrow", 32'(bcd), 32'h0099);
    chk("t3_bwrap",  32'(wrap), 32'h0);

    // 4: pause mid-period at pre=4
    up = 1'b1;
    do_load(16'h0005);
    cyc(4);
    en = 1'b0;
    cyc(25);
    chk("t4_frozen", 32'(bcd),  32'h0005);
    chk("t4_notick", 32'(tick), 32'h0);
    en = 1'b1;
    cyc(5);
    chk("t4_pre9", 32'(bcd), 32'h0005);
    cyc(1);
    chk("t4_step", 32'(bcd),  32'h0006);
    chk("t4_tick", 32'(tick), 32'h1);

    // 5: clamp, load on step edge, load while disabled
    do_load(16'hFA37);
    chk("t5_clamp", 32'(bcd), 32'h9937);
    do_load(16'h1233);
    cyc(9);
    do_load(16'h1234);
    chk("t5_ld_step", 32'(bcd),  32'h1234);
    chk("t5_ld_tick", 32'(tick), 32'h0);
    cyc(9);
    chk("t5_hold", 32'(bcd), 32'h1234);
    cyc(1);
    chk("t5_next", 32'(bcd), 32'h1235);
    en = 1'b0;
    do_load(16'h4321);
    chk("t5_ld_dis", 32'(bcd), 32'h4321);
    en = 1'b1;

    // 6: leading-zero blanking and reset mid-period
    blank_lz = 1'b1;
    do_load(16'h0070);
    chk("t6_0070", 32'(hex), 32'({SB, SB, S7, S0}));
    do_load(16'h0102);
    chk("t6_0102", 32'(hex), 32'({SB, S1, S0, S2}));
    do_load(16'h0000);
    chk("t6_0000", 32'(hex), 32'({SB, SB, SB, S0}));
    blank_lz = 1'b0;
    #1;
    chk("t6_noblank", 32'(hex), 32'({S0, S0, S0, S0}));
    do_load(16'h0042);
    cyc(7);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_rst", 32'(bcd), 32'h0000);
    cyc(9);
    chk("t6_rst_hold", 32'(bcd), 32'h0000);
    cyc(1);
    chk("t6_rst_step", 32'(bcd),  32'h0001);
    chk("t6_rst_tick", 32'(tick), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
